// File: rtl/io_bus_master.sv
// CPU-side initiator for the active-low CS_/RD_/WR_ IO bus: turns single-word
// requests into setup/strobe/hold cycles and runs the Int_req/Int_ack handshake.
module io_bus_master #(
   parameter int AW        = 10,
   parameter int DW        = 32,
   parameter int SETUP_CYC = 1,
   parameter int STRB_CYC  = 1
) (
   input  logic          Clk,
   input  logic          Reset_,
   input  logic          Req,
   input  logic          We,
   input  logic [AW-1:0] Addr,
   input  logic [DW-1:0] Wdata,
   output logic [DW-1:0] Rdata,
   output logic          Busy,
   output logic          Done,
   output logic          CS_,
   output logic          RD_,
   output logic          WR_,
   output logic [AW-1:0] IO_Addr,
   inout  wire  [DW-1:0] Data,
   input  logic          Int_req,
   output logic          Int_ack,
   output logic          Int_pend,
   input  logic          Int_clr
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          cs_q, cs_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          oe_q, oe_d;
   logic          ack_q, ack_d;
   logic          pend_q, pend_d;
   logic          setup_last, strb_last, capture;

   assign setup_last = (cnt_q == 4'(SETUP_CYC - 1));
   assign strb_last  = (cnt_q == 4'(STRB_CYC - 1));

   always_ff @(posedge Clk or negedge Reset_) begin
      if (!Reset_) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b1;
         rd_q    <= 1'b1;
         wr_q    <= 1'b1;
         oe_q    <= 1'b0;
         ack_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         oe_q    <= oe_d;
         ack_q   <= ack_d;
         pend_q  <= pend_d;
      end
   end

   // Write data is only observed while oe_q is set, so it needs no reset.
   always_ff @(posedge Clk) begin
      wdata_q <= wdata_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (Req) begin
               state_d = SETUP;
               cnt_d   = '0;
            end
         end
         SETUP: begin
            if (setup_last) begin
               state_d = STROBE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         STROBE: begin
            if (strb_last) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus pins are decoded from the next state so every pin comes straight off a flop.
   always_comb begin
      we_d    = we_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      if (state_q == IDLE && Req) begin
         we_d    = We;
         wdata_d = Wdata;
         addr_d  = Addr;
      end
      busy_d  = (state_d != IDLE);
      cs_d    = (state_d == IDLE);
      done_d  = (state_d == HOLD);
      rd_d    = !(state_d == STROBE && !we_d);
      wr_d    = !(state_d == STROBE && we_d);
      oe_d    = (state_d != IDLE) && we_d;
      rdata_d = (state_q == STROBE && state_d == HOLD && !we_q) ? Data : rdata_q;
   end

   // Ack simply follows the request level; pend captures only on a fresh handshake.
   assign capture = Int_req && !ack_q;
   assign ack_d   = Int_req;
   assign pend_d  = capture || (pend_q && !Int_clr);

   assign Data     = oe_q ? wdata_q : {DW{1'bz}};
   assign Rdata    = rdata_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign CS_      = cs_q;
   assign RD_      = rd_q;
   assign WR_      = wr_q;
   assign IO_Addr  = addr_q;
   assign Int_ack  = ack_q;
   assign Int_pend = pend_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master: two instances (default and stretched
// timing) against a transaction-level model of the bus, memory and interrupts.
module tb_io_bus_master;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int S0 = 1;
   localparam int T0 = 1;
   localparam int S1 = 3;
   localparam int T1 = 2;

   typedef struct {
      bit          we;
      bit [AW-1:0] addr;
      bit [DW-1:0] wdata;
      bit [DW-1:0] rdata;
      int          e0;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   edge_n = 0;
   int   vectors = 0;
   int   miscompares = 0;

   logic          req [2];
   logic          we [2];
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];
   logic          int_req [2];
   logic          int_clr [2];
   logic [DW-1:0] rdata [2];
   logic          busy [2];
   logic          done [2];
   logic          cs_n [2];
   logic          rd_n [2];
   logic          wr_n [2];
   logic [AW-1:0] io_addr [2];
   logic          int_ack [2];
   logic          int_pend [2];
   wire  [DW-1:0] data0;
   wire  [DW-1:0] data1;

   txn_t          exp_q [2][$];
   int            next_ok [2];
   int            wr_end [2];
   bit            wr_active [2];
   bit [DW-1:0]   keeper [2];
   bit [DW-1:0]   model_rd [2];
   bit [AW-1:0]   last_addr [2];
   bit            m_ack [2];
   bit            m_pend [2];
   bit [DW-1:0]   rmem [2][1024];
   bit [DW-1:0]   pmem [2][1024];
   bit            pw [2][1024];
   logic [DW-1:0] drv_val [2];

   io_bus_master #(.AW(AW), .DW(DW), .SETUP_CYC(S0), .STRB_CYC(T0)) u_dut0 (
      .Clk(clk), .Reset_(rst_n), .Req(req[0]), .We(we[0]), .Addr(addr[0]),
      .Wdata(wdata[0]), .Rdata(rdata[0]), .Busy(busy[0]), .Done(done[0]),
      .CS_(cs_n[0]), .RD_(rd_n[0]), .WR_(wr_n[0]), .IO_Addr(io_addr[0]),
      .Data(data0), .Int_req(int_req[0]), .Int_ack(int_ack[0]),
      .Int_pend(int_pend[0]), .Int_clr(int_clr[0])
   );

   io_bus_master #(.AW(AW), .DW(DW), .SETUP_CYC(S1), .STRB_CYC(T1)) u_dut1 (
      .Clk(clk), .Reset_(rst_n), .Req(req[1]), .We(we[1]), .Addr(addr[1]),
      .Wdata(wdata[1]), .Rdata(rdata[1]), .Busy(busy[1]), .Done(done[1]),
      .CS_(cs_n[1]), .RD_(rd_n[1]), .WR_(wr_n[1]), .IO_Addr(io_addr[1]),
      .Data(data1), .Int_req(int_req[1]), .Int_ack(int_ack[1]),
      .Int_pend(int_pend[1]), .Int_clr(int_clr[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic int s_of(input int k);
      return (k == 0) ? S0 : S1;
   endfunction

   function automatic int t_of(input int k);
      return (k == 0) ? T0 : T1;
   endfunction

   function automatic bit [DW-1:0] f_init(input int k, input int a);
      if (a == 1023) return 32'h12345678;
      return (32'h9E3779B9 * 32'(a + 1)) ^ 32'(k << 28);
   endfunction

   function automatic bit [DW-1:0] pval(input int k, input bit [AW-1:0] a);
      return pw[k][a] ? pmem[k][a] : f_init(k, int'(a));
   endfunction

   // Peripheral: answers reads while RD_ is low, otherwise parks a random
   // pattern on the bus whenever the master has no business driving it.
   always @* begin
      for (int k = 0; k < 2; k++)
         drv_val[k] = (rd_n[k] == 1'b0) ? pval(k, io_addr[k]) : keeper[k];
   end
   assign data0 = wr_active[0] ? {DW{1'bz}} : drv_val[0];
   assign data1 = wr_active[1] ? {DW{1'bz}} : drv_val[1];

   always @(posedge clk) begin
      if (rst_n && !cs_n[0] && !wr_n[0]) begin
         pmem[0][io_addr[0]] <= data0;
         pw[0][io_addr[0]]   <= 1'b1;
      end
      if (rst_n && !cs_n[1] && !wr_n[1]) begin
         pmem[1][io_addr[1]] <= data1;
         pw[1][io_addr[1]]   <= 1'b1;
      end
   end

   // Interrupt rules: a request while unacknowledged is taken and flagged;
   // the ack lasts as long as the request; the CPU clear loses to a new capture.
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_ack[k]  <= 1'b0;
            m_pend[k] <= 1'b0;
         end else if (int_req[k] && !m_ack[k]) begin
            m_ack[k]  <= 1'b1;
            m_pend[k] <= 1'b1;
         end else begin
            if (!int_req[k]) m_ack[k] <= 1'b0;
            if (int_clr[k]) m_pend[k] <= 1'b0;
         end
      end
   end

   task automatic chk32(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s[%0d] edge=%0d actual=%h expected=%h", name, k, edge_n, act, exp);
      end
   endtask

   task automatic chk1(input int k, input string name, input logic act, input logic exp);
      chk32(k, name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic mon(input int k, input logic c, input logic r, input logic w,
                      input logic b, input logic dn, input logic [AW-1:0] ia,
                      input logic [DW-1:0] rd, input logic [DW-1:0] dat,
                      input logic ack, input logic pend);
      int   s, t, rel;
      bit   in_strb;
      txn_t x;
      s = s_of(k);
      t = t_of(k);
      chk1(k, "int_ack", ack, m_ack[k]);
      chk1(k, "int_pend", pend, m_pend[k]);
      if (exp_q[k].size() != 0 && edge_n >= exp_q[k][0].e0) begin
         x       = exp_q[k][0];
         rel     = edge_n - x.e0;
         in_strb = (rel >= s) && (rel < s + t);
         chk1(k, "cs_n", c, 1'b0);
         chk1(k, "busy", b, 1'b1);
         chk1(k, "done", dn, rel == s + t);
         chk1(k, "rd_n", r, !(in_strb && !x.we));
         chk1(k, "wr_n", w, !(in_strb && x.we));
         chk32(k, "io_addr", 32'(ia), 32'(x.addr));
         if (x.we) chk32(k, "data_wr", dat, x.wdata);
         else if (in_strb) chk32(k, "data_rd", dat, x.rdata);
         else chk32(k, "data_keep", dat, keeper[k]);
         if (rel == s + t && !x.we) begin
            chk32(k, "rdata", rd, x.rdata);
            model_rd[k] = x.rdata;
         end else begin
            chk32(k, "rdata_hold", rd, model_rd[k]);
         end
         if (rel == s + t) begin
            if (x.we) chk32(k, "mem_wr", pval(k, x.addr), x.wdata);
            last_addr[k] = x.addr;
            void'(exp_q[k].pop_front());
         end
      end else begin
         chk1(k, "idle_cs_n", c, 1'b1);
         chk1(k, "idle_rd_n", r, 1'b1);
         chk1(k, "idle_wr_n", w, 1'b1);
         chk1(k, "idle_busy", b, 1'b0);
         chk1(k, "idle_done", dn, 1'b0);
         chk32(k, "idle_io_addr", 32'(ia), 32'(last_addr[k]));
         chk32(k, "idle_rdata", rd, model_rd[k]);
         if (!wr_active[k]) chk32(k, "idle_data_z", dat, keeper[k]);
      end
   endtask

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            model_rd[k]  = '0;
            last_addr[k] = '0;
         end
      end else begin
         mon(0, cs_n[0], rd_n[0], wr_n[0], busy[0], done[0], io_addr[0], rdata[0], data0, int_ack[0], int_pend[0]);
         mon(1, cs_n[1], rd_n[1], wr_n[1], busy[1], done[1], io_addr[1], rdata[1], data1, int_ack[1], int_pend[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0;
         if (wr_active[k] && edge_n >= wr_end[k]) wr_active[k] = 1'b0;
         keeper[k] = $urandom;
         if ($urandom_range(7) == 0) int_req[k] = !int_req[k];
         int_clr[k] = ($urandom_range(3) == 0);
      end
   endtask

   task automatic drive(input int k, input bit r, input bit w, input bit [AW-1:0] a, input bit [DW-1:0] d);
      txn_t x;
      req[k]   = r;
      we[k]    = w;
      addr[k]  = a;
      wdata[k] = d;
      if (r && (edge_n + 1 >= next_ok[k])) begin
         x.we    = w;
         x.addr  = a;
         x.wdata = d;
         x.e0    = edge_n + 1;
         x.rdata = w ? '0 : rmem[k][a];
         if (w) begin
            rmem[k][a]   = d;
            wr_active[k] = 1'b1;
            wr_end[k]    = x.e0 + s_of(k) + t_of(k) + 1;
         end
         next_ok[k] = x.e0 + s_of(k) + t_of(k) + 2;
         exp_q[k].push_back(x);
      end
   endtask

   task automatic issue(input int k, input bit w, input bit [AW-1:0] a, input bit [DW-1:0] d);
      tick();
      for (int n = 0; n < 64 && (edge_n + 1 < next_ok[k]); n++) tick();
      drive(k, 1'b1, w, a, d);
   endtask

   task automatic reset_checks(input int k, input logic [DW-1:0] dat);
      chk1(k, "rst_cs_n", cs_n[k], 1'b1);
      chk1(k, "rst_rd_n", rd_n[k], 1'b1);
      chk1(k, "rst_wr_n", wr_n[k], 1'b1);
      chk1(k, "rst_busy", busy[k], 1'b0);
      chk1(k, "rst_done", done[k], 1'b0);
      chk1(k, "rst_int_ack", int_ack[k], 1'b0);
      chk1(k, "rst_int_pend", int_pend[k], 1'b0);
      chk32(k, "rst_io_addr", 32'(io_addr[k]), 32'h0);
      chk32(k, "rst_rdata", rdata[k], 32'h0);
      chk32(k, "rst_data_z", dat, keeper[k]);
   endtask

   initial begin
      int e0r;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
         int_req[k] = 1'b0; int_clr[k] = 1'b0;
         next_ok[k] = 0; wr_active[k] = 1'b0; keeper[k] = $urandom;
         for (int i = 0; i < 1024; i++) rmem[k][i] = f_init(k, i);
      end
      #1 rst_n = 1'b0;
      #2;
      reset_checks(0, data0);
      reset_checks(1, data1);
      tick();
      rst_n = 1'b1;

      issue(0, 1'b1, 10'h005, 32'hDEADBEEF);
      issue(0, 1'b0, 10'h3FF, 32'h0);
      issue(1, 1'b1, 10'h005, 32'hDEADBEEF);
      issue(1, 1'b0, 10'h3FF, 32'h0);
      issue(0, 1'b0, 10'h005, 32'h0);

      // Req held high continuously: accepted only once per completed cycle.
      for (int n = 0; n < 30; n++) begin
         tick();
         for (int k = 0; k < 2; k++)
            drive(k, 1'b1, 1'($urandom_range(1)), 10'($urandom_range(15)), $urandom);
      end

      for (int n = 0; n < 3000; n++) begin
         tick();
         for (int k = 0; k < 2; k++)
            drive(k, $urandom_range(3) != 0, 1'($urandom_range(1)),
                  ($urandom_range(1) != 0) ? 10'($urandom_range(15)) : 10'($urandom), $urandom);
      end

      // Asynchronous reset landing in the strobe phase of a write.
      issue(1, 1'b1, 10'h2A5, 32'hA5A55A5A);
      e0r = edge_n + 1;
      for (int n = 0; n < 16 && edge_n < e0r + S1; n++) tick();
      chk1(1, "pre_rst_wr_n", wr_n[1], 1'b0);
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         next_ok[k]   = 0;
         wr_active[k] = 1'b0;
      end
      #1;
      reset_checks(0, data0);
      reset_checks(1, data1);
      tick();
      rst_n = 1'b1;
      issue(1, 1'b0, 10'h3FF, 32'h0);
      issue(0, 1'b0, 10'h3FF, 32'h0);
      issue(1, 1'b0, 10'h005, 32'h0);

      repeat (20) tick();
      for (int k = 0; k < 2; k++) chk32(k, "queue_drained", 32'(exp_q[k].size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
